// File: rtl/pam_pkg.sv
// Shared PAM constants: sample width, symbol encoding and the signed level alphabet.
// Used by both the PAM mixer and the QAM demodulator.
package pam_pkg;

  localparam int DATA_W = 8;
  localparam int LVL_W  = 3;

  typedef logic signed [LVL_W-1:0] lvl_t;

  typedef enum logic [1:0] {
    SYM_N3 = 2'b00,
    SYM_N1 = 2'b01,
    SYM_P1 = 2'b10,
    SYM_P3 = 2'b11
  } sym_e;

  localparam lvl_t LVL_N3 = lvl_t'(-3);
  localparam lvl_t LVL_N1 = lvl_t'(-1);
  localparam lvl_t LVL_P1 = lvl_t'(1);
  localparam lvl_t LVL_P3 = lvl_t'(3);
  localparam lvl_t LVL_ZERO = lvl_t'(0);

endpackage

// File: rtl/pam_level_map.sv
// Combinational PAM symbol to signed amplitude level lookup.
module pam_level_map
  import pam_pkg::*;
(
  input  logic [1:0] data_in,
  output lvl_t       level
);

  always_comb begin
    level = LVL_ZERO;
    case (sym_e'(data_in))
      SYM_N3:  level = LVL_N3;
      SYM_N1:  level = LVL_N1;
      SYM_P1:  level = LVL_P1;
      SYM_P3:  level = LVL_P3;
      default: level = LVL_ZERO;
    endcase
  end

endmodule

// File: rtl/pam_mixer.sv
// PAM mixer: scales the incoming carrier by a symbol level latched at each upward
// zero crossing, so a symbol always spans whole carrier periods.
module pam_mixer #(
  parameter int DATA_W = pam_pkg::DATA_W,
  parameter int SHIFT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               data_in,
  input  logic signed [DATA_W-1:0] sin_in,
  output logic signed [DATA_W-1:0] signal_out
);

  import pam_pkg::*;

  localparam int PROD_W = DATA_W + LVL_W;

  logic signed [DATA_W-1:0] sin_q;
  lvl_t                     lvl;
  lvl_t                     lvl_map;
  logic                     crossing;
  logic signed [PROD_W-1:0] sin_ext;
  logic signed [PROD_W-1:0] lvl_ext;
  logic signed [PROD_W-1:0] prod;

  // Arithmetic shift floors toward minus infinity; the full-scale result fits
  // in DATA_W bits, so truncation to the low bits never wraps.
  function automatic logic signed [DATA_W-1:0] shift_trunc(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] s;
    s = p >>> SHIFT;
    return s[DATA_W-1:0];
  endfunction

  pam_level_map u_level_map (
    .data_in (data_in),
    .level   (lvl_map)
  );

  assign crossing = sin_q[DATA_W-1] && !sin_in[DATA_W-1];
  assign sin_ext  = sin_q;
  assign lvl_ext  = lvl;
  assign prod     = sin_ext * lvl_ext;

  // Stage p0: carrier delay and level latch; stage p1: scaled output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q      <= '0;
      lvl        <= LVL_ZERO;
      signal_out <= '0;
    end else begin
      sin_q      <= sin_in;
      if (crossing)
        lvl <= lvl_map;
      signal_out <= shift_trunc(prod);
    end
  end

endmodule

// File: tb/tb_pam_mixer.sv
// Self-checking bench for pam_mixer against an integer reference model.
module tb_pam_mixer;

  logic              clk;
  logic              rst;
  logic [1:0]        data_in;
  logic signed [7:0] sin_in;
  logic signed [7:0] signal_out;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_sinq = 0;
  int m_lvl  = 0;
  int m_out  = 0;
  int levels [4] = '{-3, -1, 1, 3};

  pam_mixer #(.DATA_W(8), .SHIFT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .sin_in     (sin_in),
    .signal_out (signal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int floor_div4(input int p);
    if (p >= 0) return p / 4;
    return -((-p + 3) / 4);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, advance one clock, update the model, compare.
  task automatic step(input int s, input int d, input string tag);
    int nxt;
    sin_in  = 8'(s);
    data_in = 2'(d);
    @(posedge clk);
    nxt = floor_div4(m_sinq * m_lvl);
    if (m_sinq < 0 && s >= 0) m_lvl = levels[d];
    m_sinq = s;
    m_out  = nxt;
    #1;
    check(tag, signal_out, m_out);
  endtask

  task automatic model_reset();
    m_sinq = 0;
    m_lvl  = 0;
    m_out  = 0;
  endtask

  initial begin
    rst     = 1'b1;
    data_in = 2'b00;
    sin_in  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", signal_out, 0);
    rst = 1'b0;

    // Positive carrier with no crossing leaves the output at zero
    for (int i = 0; i < 5; i++) step(50, 3, "no_cross");
    check("no_cross_zero", signal_out, 0);

    // Level load at crossing -5 -> 100
    step(-5, 3, "load_a");
    step(100, 3, "load_b");
    step(100, 3, "load_c");
    check("load_75", signal_out, 75);

    // Symbol change mid-period is ignored until the next crossing
    step(100, 0, "mid_a");
    check("mid_hold_75", signal_out, 75);
    step(-20, 0, "mid_b");
    check("mid_hold_75b", signal_out, 75);
    step(100, 0, "mid_c");
    step(100, 0, "mid_d");
    check("mid_new_m75", signal_out, -75);

    // Rounding toward minus infinity
    step(-10, 2, "rnd_a");
    step(0, 2, "rnd_b");
    step(-127, 2, "rnd_c");
    step(-127, 2, "rnd_d");
    check("round_p1", signal_out, -32);
    step(0, 3, "rnd_e");
    step(-127, 3, "rnd_f");
    step(-127, 3, "rnd_g");
    check("round_p3", signal_out, -96);

    // Extremes
    step(0, 0, "ext_a");
    step(-128, 0, "ext_b");
    step(-128, 0, "ext_c");
    check("ext_m3_m128", signal_out, 96);
    step(0, 1, "ext_d");
    step(127, 1, "ext_e");
    step(127, 1, "ext_f");
    check("ext_m1_127", signal_out, -32);

    // Stalled carrier: level frozen regardless of data_in
    for (int i = 0; i < 20; i++) step(60, $urandom_range(0, 3), "stall");
    check("stall_out", signal_out, -15);

    // Random carrier and symbols
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 255) - 128, $urandom_range(0, 3), "rand");

    // Sinusoid-like triangle carrier with random symbols per period
    for (int p = 0; p < 8; p++) begin
      int d;
      d = $urandom_range(0, 3);
      for (int t = 0; t < 16; t++) begin
        int s;
        s = (t < 8) ? (-112 + 32 * t) : (112 - 32 * (t - 8));
        step(s, d, "tri");
      end
    end

    // Asynchronous reset mid-symbol
    step(-40, 3, "pre_rst_a");
    step(90, 3, "pre_rst_b");
    step(90, 3, "pre_rst_c");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", signal_out, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_out", signal_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(70 + i, 3, "post_rst");
    check("post_rst_zero", signal_out, 0);
    step(-30, 3, "post_rst_x");
    step(80, 3, "post_rst_y");
    step(80, 3, "post_rst_z");
    check("post_rst_load", signal_out, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
